// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: turns the memory-stage access into a
// valid/ready request plus response transaction and returns the extended
// load result to the M-to-W register, stalling the pipeline meanwhile.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  M_valid,
    input  logic                  M_mem_read,
    input  logic                  M_mem_write,
    input  logic [2:0]            M_funct3,
    input  logic [DATA_WIDTH-1:0] M_addr,
    input  logic [DATA_WIDTH-1:0] M_wdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_be,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
    output logic [DATA_WIDTH-1:0] M_mem_data,
    output logic                  stall,
    output logic                  misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t          state;
    logic [2:0]      funct3_q;   // size/sign of the access in flight
    logic [1:0]      lane_q;     // byte offset of the access in flight

    logic            acc;
    logic            both;
    logic            illegal_f3;
    logic            unaligned;
    logic            bad;
    logic            start;
    logic [3:0]      be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [DATA_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;

    // Classify the access currently presented by the memory stage.
    always_comb begin
        acc  = M_valid & (M_mem_read ^ M_mem_write);
        both = M_valid & M_mem_read & M_mem_write;
        if (M_mem_write) begin
            // Stores only come in B, H and W.
            illegal_f3 = M_funct3[2] | (M_funct3[1:0] == 2'b11);
        end else begin
            // Loads reject 011, 110 and 111.
            illegal_f3 = (M_funct3[1:0] == 2'b11) | (M_funct3 == 3'b110);
        end
        unaligned = ((M_funct3[1:0] == 2'b01) & M_addr[0]) |
                    ((M_funct3[1:0] == 2'b10) & (M_addr[1:0] != 2'b00));
        bad   = acc & (illegal_f3 | unaligned);
        start = acc & ~bad;
    end

    // Byte enables and store-data replication across the byte lanes.
    always_comb begin
        // NOTE: every branch assigns both outputs, so no latch can be inferred.
        case (M_funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << M_addr[1:0];
                wdata_next = {4{M_wdata[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << M_addr[1:0];
                wdata_next = {2{M_wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = M_wdata;
            end
        endcase
    end

    // Select the addressed lane of the response word and extend it.
    always_comb begin
        load_word = mem_rsp_rdata >> {lane_q, 3'b000};
        load_byte = load_word[7:0];
        load_half = load_word[15:0];
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{~funct3_q[2] & load_byte[7]}}, load_byte};
            2'b01:   load_ext = {{16{~funct3_q[2] & load_half[15]}}, load_half};
            default: load_ext = load_word;
        endcase
    end

    // Transaction FSM with registered request fields and load result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_be    <= '0;
            funct3_q      <= '0;
            lane_q        <= '0;
            M_mem_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= M_mem_write;
                        mem_req_addr  <= {M_addr[DATA_WIDTH-1:2], 2'b00};
                        mem_req_wdata <= wdata_next;
                        mem_req_be    <= be_next;
                        funct3_q      <= M_funct3;
                        lane_q        <= M_addr[1:0];
                    end
                end
                REQ: begin
                    // Fields stay put until the memory accepts the request.
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= mem_req_we ? DONE : RESP;
                    end
                end
                RESP: begin
                    if (mem_rsp_valid) begin
                        M_mem_data <= load_ext;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // Pipeline advances on this edge; next access starts in IDLE.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall covers the issuing IDLE cycle through RESP; DONE releases it.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:     stall = start;
                REQ:      stall = 1'b1;
                RESP:     stall = 1'b1;
                default:  stall = 1'b0;
            endcase
        end
        misaligned = ~rst & (bad | both);
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by random
// accesses, all compared against an arithmetic reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        M_valid, M_mem_read, M_mem_write;
    logic [2:0]  M_funct3;
    logic [31:0] M_addr, M_wdata;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic [31:0] M_mem_data;
    logic        stall, misaligned;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_load = 32'h0;

    mem_access_unit #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .M_valid       (M_valid),
        .M_mem_read    (M_mem_read),
        .M_mem_write   (M_mem_write),
        .M_funct3      (M_funct3),
        .M_addr        (M_addr),
        .M_wdata       (M_wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_be    (mem_req_be),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .M_mem_data    (M_mem_data),
        .stall         (stall),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_bad(input bit v, input bit r, input bit w,
                                 input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        if (!v || (!r && !w)) return 1'b0;
        if (r && w) return 1'b1;
        if (r) legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else   legal = (f3 inside {3'd0, 3'd1, 3'd2});
        if (!legal) return 1'b1;
        return (a % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        if (sz >= 4) return 4'hF;
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        int sz = m_size(f3);
        if (sz == 1) return 32'((w % 256) * 32'h0101_0101);
        if (sz == 2) return 32'((w % 65536) * 32'h0001_0001);
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
        int     sz = m_size(f3);
        longint v;
        if (sz >= 4) return rdata;
        v = (longint'(rdata) >> (8 * (a % 4))) % (longint'(1) << (8 * sz));
        if (f3 < 3'd4 && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        M_valid     = 1'b0;
        M_mem_read  = 1'b0;
        M_mem_write = 1'b0;
    endtask

    // Legal access from the IDLE cycle through DONE; returns at the next IDLE.
    task automatic do_access(input bit is_load, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int rdy_dly,
                             input int rsp_dly, output int stalls);
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        e_addr = addr & 32'hFFFF_FFFC;
        e_be   = m_be(f3, addr);
        e_wd   = m_wdata(f3, wdata);
        stalls = 0;
        M_valid = 1'b1; M_mem_read = is_load; M_mem_write = !is_load;
        M_funct3 = f3; M_addr = addr; M_wdata = wdata;
        #1;
        check("idle_stall", stall, 1);
        check("idle_misaligned", misaligned, 0);
        check("idle_req_valid", mem_req_valid, 0);
        if (stall) stalls++;
        step();
        for (int k = 0; k <= rdy_dly; k++) begin
            mem_req_ready = (k == rdy_dly);
            mem_rsp_valid = 1'b1;              // stray response, must be ignored
            mem_rsp_rdata = $urandom;
            #1;
            check("req_valid", mem_req_valid, 1);
            check("req_we", mem_req_we, !is_load);
            check("req_addr", mem_req_addr, e_addr);
            check("req_be", {28'h0, mem_req_be}, {28'h0, e_be});
            if (!is_load) check("req_wdata", mem_req_wdata, e_wd);
            check("req_stall", stall, 1);
            if (stall) stalls++;
            step();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        if (is_load) begin
            for (int k = 0; k <= rsp_dly; k++) begin
                mem_rsp_valid = (k == rsp_dly);
                mem_rsp_rdata = (k == rsp_dly) ? rdata : $urandom;
                #1;
                check("resp_req_valid", mem_req_valid, 0);
                check("resp_stall", stall, 1);
                if (stall) stalls++;
                step();
            end
            mem_rsp_valid = 1'b0;
            last_load = m_load(f3, addr, rdata);
        end
        #1;
        check("done_stall", stall, 0);
        check("done_req_valid", mem_req_valid, 0);
        check("done_mem_data", M_mem_data, last_load);
        check("stall_cycles", stalls, (is_load ? 3 : 2) + rdy_dly + (is_load ? rsp_dly : 0));
        step();
        idle_inputs();
    endtask

    // Rejected access: flag raised, no request, no stall, result untouched.
    task automatic bad_access(input bit r, input bit w, input logic [2:0] f3,
                              input logic [31:0] addr);
        M_valid = 1'b1; M_mem_read = r; M_mem_write = w;
        M_funct3 = f3; M_addr = addr; M_wdata = $urandom;
        #1;
        check("bad_misaligned", misaligned, m_bad(1'b1, r, w, f3, addr));
        check("bad_stall", stall, 0);
        check("bad_req_valid", mem_req_valid, 0);
        step();
        check("bad_req_valid_hold", mem_req_valid, 0);
        check("bad_misaligned_hold", misaligned, 1);
        check("bad_mem_data", M_mem_data, last_load);
        idle_inputs();
        #1;
        check("bad_misaligned_clear", misaligned, 0);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s1, s2, s;
        bit r, w;
        logic [2:0]  f3;
        logic [31:0] a;

        rst = 1'b1;
        M_valid = 1'b1; M_mem_read = 1'b1; M_mem_write = 1'b1;
        M_funct3 = 3'b011; M_addr = 32'h1; M_wdata = 32'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
        step();
        step();
        check("rst_stall", stall, 0);
        check("rst_misaligned", misaligned, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_req_we", mem_req_we, 0);
        check("rst_req_addr", mem_req_addr, 0);
        check("rst_req_wdata", mem_req_wdata, 0);
        check("rst_req_be", {28'h0, mem_req_be}, 0);
        check("rst_mem_data", M_mem_data, 0);
        idle_inputs();
        rst = 1'b0;
        step();
        check("idle_no_stall", stall, 0);

        // Directed loads.
        do_access(1'b1, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, s);
        do_access(1'b1, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_FFFF, 0, 0, s);
        do_access(1'b1, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_FFFF, 0, 0, s);
        do_access(1'b1, 3'b101, 32'h0000_0202, 32'h0, 32'hBEEF_1234, 1, 2, s);
        do_access(1'b1, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_0000, 0, 1, s);

        // Store with ready held low for 4 cycles.
        do_access(1'b0, 3'b001, 32'h0000_0302, 32'h0000_ABCD, 32'h0, 4, 0, s);

        // Rejected accesses.
        bad_access(1'b1, 1'b0, 3'b010, 32'h0000_0101);
        bad_access(1'b0, 1'b1, 3'b001, 32'h0000_0301);
        bad_access(1'b1, 1'b0, 3'b011, 32'h0000_0100);
        bad_access(1'b0, 1'b1, 3'b100, 32'h0000_0100);
        bad_access(1'b1, 1'b1, 3'b010, 32'h0000_0100);

        // Back-to-back LW then SB.
        do_access(1'b1, 3'b010, 32'h0000_0500, 32'h0, 32'h1357_9BDF, 0, 0, s1);
        do_access(1'b0, 3'b000, 32'h0000_0601, 32'h0000_00A5, 32'h0, 0, 0, s2);
        check("b2b_stall_total", s1 + s2, 5);

        // Reset while waiting for the response; late response ignored.
        M_valid = 1'b1; M_mem_read = 1'b1; M_mem_write = 1'b0;
        M_funct3 = 3'b010; M_addr = 32'h0000_0400;
        mem_req_ready = 1'b1;
        step();                                  // REQ
        step();                                  // RESP
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_resp_stall", stall, 0);
        check("rst_resp_misaligned", misaligned, 0);
        idle_inputs();
        step();
        rst = 1'b0;
        last_load = 32'h0;
        #1;
        check("rst_resp_req_valid", mem_req_valid, 0);
        check("rst_resp_mem_data", M_mem_data, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h1234_5678;
        step();
        mem_rsp_valid = 1'b0;
        check("late_rsp_mem_data", M_mem_data, 0);
        check("late_rsp_stall", stall, 0);
        check("late_rsp_req_valid", mem_req_valid, 0);
        step();
        check("late_rsp_no_done", stall, 0);

        // Random accesses against the model.
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom & 32'h0000_FFFF;
            case ($urandom_range(0, 9))
                0:       begin r = 1'b1; w = 1'b1; end
                1:       begin r = 1'b0; w = 1'b0; end
                2, 3, 4: begin r = 1'b0; w = 1'b1; end
                default: begin r = 1'b1; w = 1'b0; end
            endcase
            if (!r && !w) begin
                idle_inputs();
                #1;
                check("rand_idle_stall", stall, 0);
                step();
            end else if (m_bad(1'b1, r, w, f3, a)) begin
                bad_access(r, w, f3, a);
            end else begin
                do_access(r, f3, a, $urandom, $urandom,
                          $urandom_range(0, 2), $urandom_range(0, 2), s);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
